cfg_write_scheduler: RTL and testbench

Arbitrates write requests to the display configuration registers (colors, sprite position, misc) between two requesters: the SPI command receiver and the on-chip sprite animator. Accepted writes are buffered in a small FIFO and committed to the register bank only while the video timing generator reports vertical blanking, so a frame never renders with half-updated configuration. Sits between the requesters and the register bank's single write port.

---
 rtl/cfg_pkg.sv | 29 ++
 rtl/cfg_fifo.sv | 55 +++++
 rtl/cfg_write_scheduler.sv | 134 +++++++++++++
 tb/tb_cfg_write_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cfg_pkg
// Purpose  : Shared display-config constants, register indices, write request
// Revision : 1.0 - initial release
// ============================================================================
package cfg_pkg;

  localparam int NUM_REGISTERS = 7;
  localparam int LEN_REGISTER  = 8;
  localparam int AW            = $clog2(NUM_REGISTERS);

  typedef enum logic [AW-1:0] {
    REG_COLOR1,
    REG_COLOR2,
    REG_COLOR3,
    REG_COLOR4,
    REG_SPRITE_X,
    REG_SPRITE_Y,
    REG_MISC
  } cfg_reg_e;

  typedef struct packed {
    logic [AW-1:0]           addr;
    logic [LEN_REGISTER-1:0] data;
  } cfg_req_t;

endpackage
`default_nettype wire

// File: rtl/cfg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cfg_fifo
// Purpose  : Synchronous FIFO of pending config write requests
// Revision : 1.0 - initial release
// ============================================================================
module cfg_fifo
  import cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  cfg_req_t      push_data_i,
  input  logic          pop_i,
  output cfg_req_t      pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  cfg_req_t      r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push_i && !pop_i)      r_count <= r_count + 1'b1;
      else if (pop_i && !push_i) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign pop_data_o = r_mem[r_rd_ptr];
  assign full_o     = (r_count == CW'(FIFO_DEPTH));
  assign empty_o    = (r_count == '0);
  assign count_o    = r_count;

endmodule
`default_nettype wire

// File: rtl/cfg_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cfg_write_scheduler
// Purpose  : Arbitrates SPI/animator config writes, commits them during vblank
// Revision : 1.0 - initial release
// ============================================================================
module cfg_write_scheduler
  import cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    spi_valid_i,
  input  logic [AW-1:0]           spi_addr_i,
  input  logic [LEN_REGISTER-1:0] spi_data_i,
  output logic                    spi_ready_o,
  input  logic                    anim_valid_i,
  input  logic [AW-1:0]           anim_addr_i,
  input  logic [LEN_REGISTER-1:0] anim_data_i,
  output logic                    anim_ready_o,
  input  logic                    vblank_i,
  output logic                    wr_en_o,
  output logic [AW-1:0]           wr_addr_o,
  output logic [LEN_REGISTER-1:0] wr_data_o,
  output logic [PW-1:0]           pending_o,
  output logic                    drop_o
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VBLANK = 2'd1,
    DRAIN       = 2'd2
  } state_e;

  state_e                  r_state, w_state_next;
  logic                    r_rr_spi;
  logic                    r_wr_en, r_drop;
  logic [AW-1:0]           r_wr_addr;
  logic [LEN_REGISTER-1:0] r_wr_data;

  logic          w_grant_spi, w_grant_anim, w_full, w_empty;
  logic          w_push, w_pop, w_bypass, w_wr_valid;
  logic [PW-1:0] w_count;
  cfg_req_t      w_push_req, w_fifo_head, w_pop_req;

  assign w_grant_spi  = spi_valid_i  && (!anim_valid_i || r_rr_spi);
  assign w_grant_anim = anim_valid_i && (!spi_valid_i  || !r_rr_spi);
  assign spi_ready_o  = w_grant_spi  && !w_full;
  assign anim_ready_o = w_grant_anim && !w_full;
  assign w_push       = spi_ready_o || anim_ready_o;

  always_comb begin
    w_push_req.addr = anim_addr_i;
    w_push_req.data = anim_data_i;
    if (w_grant_spi) begin
      w_push_req.addr = spi_addr_i;
      w_push_req.data = spi_data_i;
    end
  end

  // An empty FIFO popped in the same cycle hands the incoming request straight
  // to the write register, giving a one-cycle commit during vblank.
  assign w_bypass   = w_pop && w_empty;
  assign w_pop_req  = w_empty ? w_push_req : w_fifo_head;
  assign w_wr_valid = int'(w_pop_req.addr) < NUM_REGISTERS;

  cfg_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push && !w_bypass),
    .push_data_i (w_push_req),
    .pop_i       (w_pop && !w_bypass),
    .pop_data_o  (w_fifo_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  // The cycle that first sees vblank already pops, so a commit lands on the
  // following cycle; vblank low stops popping at once.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pop = w_push && vblank_i;
        if (w_push) w_state_next = vblank_i ? DRAIN : WAIT_VBLANK;
      end
      WAIT_VBLANK, DRAIN: begin
        w_pop = vblank_i && (!w_empty || w_push);
        if ((w_empty && (!w_push || w_pop)) ||
            ((w_count == PW'(1)) && w_pop && !w_push))
          w_state_next = IDLE;
        else if (vblank_i)
          w_state_next = DRAIN;
        else
          w_state_next = WAIT_VBLANK;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rr_spi  <= 1'b1;
      r_wr_en   <= 1'b0;
      r_drop    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push && spi_valid_i && anim_valid_i) r_rr_spi <= !r_rr_spi;
      r_wr_en <= w_pop && w_wr_valid;
      r_drop  <= w_pop && !w_wr_valid;
      if (w_pop && w_wr_valid) begin
        r_wr_addr <= w_pop_req.addr;
        r_wr_data <= w_pop_req.data;
      end
    end
  end

  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign drop_o    = r_drop;
  assign pending_o = w_count;

endmodule
`default_nettype wire

// File: tb/tb_cfg_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_write_scheduler
// Purpose  : Directed and random checks of cfg_write_scheduler against a queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_write_scheduler;
  import cfg_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int EW    = AW + LEN_REGISTER;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    spi_valid_i = 1'b0;
  logic [AW-1:0]           spi_addr_i = '0;
  logic [LEN_REGISTER-1:0] spi_data_i = '0;
  logic                    spi_ready_o;
  logic                    anim_valid_i = 1'b0;
  logic [AW-1:0]           anim_addr_i = '0;
  logic [LEN_REGISTER-1:0] anim_data_i = '0;
  logic                    anim_ready_o;
  logic                    vblank_i = 1'b0;
  logic                    wr_en_o;
  logic [AW-1:0]           wr_addr_o;
  logic [LEN_REGISTER-1:0] wr_data_o;
  logic [PW-1:0]           pending_o;
  logic                    drop_o;

  cfg_write_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .spi_valid_i  (spi_valid_i),
    .spi_addr_i   (spi_addr_i),
    .spi_data_i   (spi_data_i),
    .spi_ready_o  (spi_ready_o),
    .anim_valid_i (anim_valid_i),
    .anim_addr_i  (anim_addr_i),
    .anim_data_i  (anim_data_i),
    .anim_ready_o (anim_ready_o),
    .vblank_i     (vblank_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .pending_o    (pending_o),
    .drop_o       (drop_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference: accepted writes in order, plus who holds round-robin priority.
  logic [EW-1:0] q[$];
  logic          rr_spi = 1'b1;
  logic          acc_spi, acc_anim;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with requests already driven.
  task automatic step(input logic vb);
    logic          full, g_spi, g_anim, push, pop, exp_en, exp_drop;
    logic [EW-1:0] e;
    vblank_i = vb;
    #1;
    full   = (q.size() == DEPTH);
    g_spi  = spi_valid_i  && (!anim_valid_i || rr_spi);
    g_anim = anim_valid_i && (!spi_valid_i  || !rr_spi);
    check("spi_ready",  spi_ready_o,  g_spi && !full);
    check("anim_ready", anim_ready_o, g_anim && !full);
    push = (g_spi || g_anim) && !full;
    if (push) q.push_back(g_spi ? {spi_addr_i, spi_data_i} : {anim_addr_i, anim_data_i});
    if (push && spi_valid_i && anim_valid_i) rr_spi = !rr_spi;
    pop      = vb && (q.size() > 0);
    exp_en   = 1'b0;
    exp_drop = 1'b0;
    e        = '0;
    if (pop) begin
      e = q.pop_front();
      if (int'(e[EW-1:LEN_REGISTER]) < NUM_REGISTERS) exp_en = 1'b1;
      else exp_drop = 1'b1;
    end
    acc_spi  = push && g_spi;
    acc_anim = push && g_anim;
    @(posedge clk_i);
    #1;
    check("wr_en",   wr_en_o,   exp_en);
    check("drop",    drop_o,    exp_drop);
    check("pending", pending_o, q.size());
    if (exp_en) begin
      check("wr_addr", wr_addr_o, e[EW-1:LEN_REGISTER]);
      check("wr_data", wr_data_o, e[LEN_REGISTER-1:0]);
    end
  endtask

  task automatic new_spi();
    spi_valid_i = ($urandom_range(0, 9) < 6);
    spi_addr_i  = AW'($urandom_range(0, 7));
    spi_data_i  = LEN_REGISTER'($urandom);
  endtask

  task automatic new_anim();
    anim_valid_i = ($urandom_range(0, 9) < 6);
    anim_addr_i  = AW'($urandom_range(0, 7));
    anim_data_i  = LEN_REGISTER'($urandom);
  endtask

  initial begin
    logic vb;
    // Reset values, and ready following grant while held in reset.
    #2;
    check("rst_wr_en",   wr_en_o,   0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_drop",    drop_o,    0);
    spi_valid_i = 1'b1;
    #1;
    check("rst_spi_ready",  spi_ready_o,  1);
    check("rst_anim_ready", anim_ready_o, 0);
    spi_valid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single SPI write held until vblank.
    spi_valid_i = 1'b1; spi_addr_i = 3'd4; spi_data_i = 8'h50;
    step(1'b0);
    check("t1_pending", pending_o, 1);
    spi_valid_i = 1'b0;
    step(1'b1);
    check("t1_wr_en", wr_en_o, 1);
    check("t1_wr_data", wr_data_o, 8'h50);

    // Both requesters contending: alternating grants, then full.
    spi_valid_i  = 1'b1; spi_addr_i  = 3'd0; spi_data_i  = 8'hA0;
    anim_valid_i = 1'b1; anim_addr_i = 3'd1; anim_data_i = 8'hB0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      check("t2_grant_spi", acc_spi, (k % 2) == 0);
      if (acc_spi)  begin spi_addr_i  = 3'd2; spi_data_i  = spi_data_i + 8'd1;  end
      if (acc_anim) begin anim_addr_i = 3'd3; anim_data_i = anim_data_i + 8'd1; end
    end
    check("t2_pending", pending_o, 4);
    step(1'b0);
    check("t2_full_spi_ready", acc_spi || acc_anim, 0);

    // Two cycles of vblank on a full FIFO.
    spi_valid_i = 1'b0; anim_valid_i = 1'b0;
    step(1'b1);
    step(1'b1);
    check("t3_pending", pending_o, 2);

    // Push and pop in the same cycle.
    spi_valid_i = 1'b1; spi_addr_i = 3'd5; spi_data_i = 8'h77;
    step(1'b1);
    check("t4_pending", pending_o, 2);
    spi_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1);

    // Out-of-range address is accepted then dropped.
    spi_valid_i = 1'b1; spi_addr_i = 3'd7; spi_data_i = 8'hAA;
    step(1'b0);
    spi_valid_i = 1'b0;
    step(1'b1);
    check("t5_drop", drop_o, 1);
    check("t5_wr_en", wr_en_o, 0);

    // Reset while draining with three writes still pending.
    for (int k = 0; k < 4; k++) begin
      spi_valid_i = 1'b1; spi_addr_i = AW'(k); spi_data_i = 8'hC0 + 8'(k);
      step(1'b0);
    end
    spi_valid_i = 1'b0;
    step(1'b1);
    check("t6_pending_pre", pending_o, 3);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_rst_wr_en",   wr_en_o,   0);
    check("t6_rst_pending", pending_o, 0);
    check("t6_rst_wr_data", wr_data_o, 0);
    q.delete();
    rr_spi = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 3; k++) step(1'b1);

    // Random traffic with requesters holding requests until accepted.
    vb = 1'b0;
    new_spi();
    new_anim();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) vb = !vb;
      step(vb);
      if (acc_spi  || !spi_valid_i)  new_spi();
      if (acc_anim || !anim_valid_i) new_anim();
    end
    spi_valid_i = 1'b0; anim_valid_i = 1'b0;
    for (int k = 0; k < DEPTH + 1; k++) step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
